rf_write_arbiter: RTL

- Shares the single register-file write port between the in-order writeback stage and a long-latency unit (mul/div result return).
- Buffers long-latency results in a small FIFO and grants them the port in cycles where writeback does not write.
- Forces a pipeline stall after a bounded wait so the FIFO head cannot starve.
- Exports a pending-destination mask so decode can hold dependent instructions.

---
 rtl/rf_write_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port between the in-order writeback
//   stage and a long-latency unit (mul/div). Long-latency results are buffered
//   in a small FIFO and take the port whenever writeback does not write. If the
//   FIFO head is denied MAX_WAIT times in a row, pipe_stall is raised so the head
//   is guaranteed a slot. pending_mask lets decode hold instructions that depend
//   on a buffered destination.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   wb_valid/we/rd/data   writeback slot (rd==0 never writes)
//   lu_valid/rd/data      long-latency result, accepted when lu_ready=1
//   lu_ready          FIFO has room (registered)
//   rf_we/waddr/wdata register-file write port, one cycle after grant
//   pipe_stall        writeback must not present a valid slot
//   pending_mask      one bit per nonzero rd currently held in the FIFO
//   proto_err         sticky: wb_valid seen while pipe_stall=1
module rf_write_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_valid,
  input  logic                   wb_we,
  input  logic [ADDR_W-1:0]      wb_rd,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [ADDR_W-1:0]      lu_rd,
  input  logic [DATA_W-1:0]      lu_data,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic                   pipe_stall,
  output logic [2**ADDR_W-1:0]   pending_mask,
  output logic                   proto_err
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = 4;
  localparam int NREGS  = 2**ADDR_W;

  // FIFO storage and control state
  logic [ADDR_W-1:0] fifo_rd_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_rd_d   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              lu_ready_q, lu_ready_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Registered write port and sticky error
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              proto_err_q, proto_err_d;

  // Combinational decode
  logic              wb_wr;
  logic              fifo_nonempty;
  logic              stall_c;
  logic              push;
  logic              head_grant;
  logic              wb_grant;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic [PTR_W-1:0]  offset;
  logic [NREGS-1:0]  pending_c;

  // Grant arbitration and next-state computation. pipe_stall is a pure decode
  // of registered state, so it forces the head through regardless of wb.
  always_comb begin
    wb_wr         = wb_valid & wb_we & (wb_rd != '0);
    fifo_nonempty = (count_q != '0);
    stall_c       = (wait_cnt_q == WAIT_W'(MAX_WAIT)) & fifo_nonempty;
    push          = lu_valid & lu_ready_q;
    head_rd       = fifo_rd_q[rd_ptr_q];
    head_data     = fifo_data_q[rd_ptr_q];
    head_grant    = fifo_nonempty & (stall_c | ~wb_wr);
    wb_grant      = ~stall_c & wb_wr;

    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    wait_cnt_d  = wait_cnt_q;
    proto_err_d = proto_err_q | (stall_c & wb_valid);

    if (push) begin
      fifo_rd_d[wr_ptr_q]   = lu_rd;
      fifo_data_d[wr_ptr_q] = lu_data;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end

    if (head_grant) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    count_d    = count_q + CNT_W'(push) - CNT_W'(head_grant);
    lu_ready_d = (count_d < CNT_W'(FIFO_DEPTH));

    // A head that is present and not popped this cycle was denied.
    if (head_grant || !fifo_nonempty) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    // x0 heads are drained silently; address/data hold on idle cycles.
    if (wb_grant) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_data;
    end else if (head_grant && (head_rd != '0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head_rd;
      rf_wdata_d = head_data;
    end
  end

  // Pending destinations: an entry is live if its distance from the read
  // pointer is below the occupancy count.
  always_comb begin
    pending_c = '0;
    offset    = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr_q;
      if ((CNT_W'(offset) < count_q) && (fifo_rd_q[i] != '0)) begin
        pending_c[fifo_rd_q[i]] = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lu_ready_q  <= 1'b0;
      wait_cnt_q  <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      lu_ready_q  <= lu_ready_d;
      wait_cnt_q  <= wait_cnt_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign lu_ready     = lu_ready_q;
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign pipe_stall   = stall_c;
  assign pending_mask = pending_c;
  assign proto_err    = proto_err_q;

endmodule
